// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-instruction execute/writeback states, with outputs registered from the next state.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       immzext,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q, state_d, illegal_next;
    logic        funct_legal;
    logic [2:0]  funct_alu, imm_alu;

    logic        pcwrite_q, pcwrite_d, branch_q, branch_d;
    logic        iord_q, iord_d, memwrite_q, memwrite_d, irwrite_q, irwrite_d;
    logic        regwrite_q, regwrite_d, regdst_q, regdst_d, memtoreg_q, memtoreg_d;
    logic        alusrca_q, alusrca_d, immzext_q, immzext_d;
    logic        instr_done_q, instr_done_d, halted_q, halted_d;
    logic [1:0]  alusrcb_q, alusrcb_d, pcsrc_q, pcsrc_d;
    logic [2:0]  alucontrol_q, alucontrol_d;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            6'b100110: funct_alu = 3'b011;
            6'b100111: funct_alu = 3'b100;
            default:   funct_legal = 1'b0;
        endcase

        imm_alu = 3'b010;
        case (op)
            OP_ANDI: imm_alu = 3'b000;
            OP_ORI:  imm_alu = 3'b001;
            OP_XORI: imm_alu = 3'b011;
            default: imm_alu = 3'b010;
        endcase

        illegal_next = HALT_ON_ILLEGAL ? HALT : FETCH;

        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      state_d = MEMADR;
                    OP_RTYPE:                          state_d = funct_legal ? EXECUTE : illegal_next;
                    OP_BEQ:                            state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = IMMEX;
                    OP_J:                              state_d = JUMP;
                    default:                           state_d = illegal_next;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            IMMEX:   state_d = IMMWB;
            MEMWB, MEMWR, ALUWB, BRANCH, IMMWB, JUMP: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        // Outputs are decoded from the state being entered so they appear registered.
        pcwrite_d    = 1'b0;
        branch_d     = 1'b0;
        iord_d       = 1'b0;
        memwrite_d   = 1'b0;
        irwrite_d    = 1'b0;
        regwrite_d   = 1'b0;
        regdst_d     = 1'b0;
        memtoreg_d   = 1'b0;
        alusrca_d    = 1'b0;
        alusrcb_d    = 2'b00;
        pcsrc_d      = 2'b00;
        alucontrol_d = 3'b010;
        immzext_d    = 1'b0;
        instr_done_d = 1'b0;
        halted_d     = 1'b0;
        case (state_d)
            FETCH: begin
                irwrite_d = 1'b1;
                pcwrite_d = 1'b1;
                alusrcb_d = 2'b01;
            end
            DECODE:  alusrcb_d = 2'b11;
            MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            MEMRD:   iord_d = 1'b1;
            MEMWB: begin
                regwrite_d   = 1'b1;
                memtoreg_d   = 1'b1;
                instr_done_d = 1'b1;
            end
            MEMWR: begin
                iord_d       = 1'b1;
                memwrite_d   = 1'b1;
                instr_done_d = 1'b1;
            end
            EXECUTE: begin
                alusrca_d    = 1'b1;
                alucontrol_d = funct_alu;
            end
            ALUWB: begin
                regwrite_d   = 1'b1;
                regdst_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            BRANCH: begin
                alusrca_d    = 1'b1;
                alucontrol_d = 3'b110;
                pcsrc_d      = 2'b01;
                branch_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            IMMEX: begin
                alusrca_d    = 1'b1;
                alusrcb_d    = 2'b10;
                alucontrol_d = imm_alu;
                immzext_d    = (op[5:2] == 4'b0011);
            end
            IMMWB: begin
                regwrite_d   = 1'b1;
                instr_done_d = 1'b1;
            end
            JUMP: begin
                pcsrc_d      = 2'b10;
                pcwrite_d    = 1'b1;
                instr_done_d = 1'b1;
            end
            HALT:    halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            pcwrite_q    <= 1'b1;
            branch_q     <= 1'b0;
            iord_q       <= 1'b0;
            memwrite_q   <= 1'b0;
            irwrite_q    <= 1'b1;
            regwrite_q   <= 1'b0;
            regdst_q     <= 1'b0;
            memtoreg_q   <= 1'b0;
            alusrca_q    <= 1'b0;
            alusrcb_q    <= 2'b01;
            pcsrc_q      <= 2'b00;
            alucontrol_q <= 3'b010;
            immzext_q    <= 1'b0;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcwrite_q    <= pcwrite_d;
            branch_q     <= branch_d;
            iord_q       <= iord_d;
            memwrite_q   <= memwrite_d;
            irwrite_q    <= irwrite_d;
            regwrite_q   <= regwrite_d;
            regdst_q     <= regdst_d;
            memtoreg_q   <= memtoreg_d;
            alusrca_q    <= alusrca_d;
            alusrcb_q    <= alusrcb_d;
            pcsrc_q      <= pcsrc_d;
            alucontrol_q <= alucontrol_d;
            immzext_q    <= immzext_d;
            instr_done_q <= instr_done_d;
            halted_q     <= halted_d;
        end
    end

    // Reset loads FETCH values (enables high) so they show the instant reset releases;
    // while reset is held the enables are masked off.
    assign pcen       = (pcwrite_q | (branch_q & zero)) & reset;
    assign irwrite    = irwrite_q & reset;
    assign memwrite   = memwrite_q & reset;
    assign regwrite   = regwrite_q & reset;
    assign instr_done = instr_done_q & reset;
    assign halted     = halted_q;
    assign iord       = iord_q;
    assign regdst     = regdst_q;
    assign memtoreg   = memtoreg_q;
    assign alusrca    = alusrca_q;
    assign alusrcb    = alusrcb_q;
    assign pcsrc      = pcsrc_q;
    assign alucontrol = alucontrol_q;
    assign immzext    = immzext_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle expected output vectors plus
// hand-written reset and illegal-instruction sequences on both HALT_ON_ILLEGAL settings.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;

    logic       d1_pcen, d1_iord, d1_memwrite, d1_irwrite, d1_regwrite, d1_regdst, d1_memtoreg, d1_alusrca;
    logic [1:0] d1_alusrcb, d1_pcsrc;
    logic [2:0] d1_alucontrol;
    logic       d1_immzext, d1_instr_done, d1_halted;
    logic [3:0] d1_state;

    logic       d2_pcen, d2_iord, d2_memwrite, d2_irwrite, d2_regwrite, d2_regdst, d2_memtoreg, d2_alusrca;
    logic [1:0] d2_alusrcb, d2_pcsrc;
    logic [2:0] d2_alucontrol;
    logic       d2_immzext, d2_instr_done, d2_halted;
    logic [3:0] d2_state;

    logic [21:0] act1, act2;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(d1_pcen), .iord(d1_iord), .memwrite(d1_memwrite), .irwrite(d1_irwrite),
        .regwrite(d1_regwrite), .regdst(d1_regdst), .memtoreg(d1_memtoreg), .alusrca(d1_alusrca),
        .alusrcb(d1_alusrcb), .pcsrc(d1_pcsrc), .alucontrol(d1_alucontrol), .immzext(d1_immzext),
        .instr_done(d1_instr_done), .halted(d1_halted), .state(d1_state)
    );

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(d2_pcen), .iord(d2_iord), .memwrite(d2_memwrite), .irwrite(d2_irwrite),
        .regwrite(d2_regwrite), .regdst(d2_regdst), .memtoreg(d2_memtoreg), .alusrca(d2_alusrca),
        .alusrcb(d2_alusrcb), .pcsrc(d2_pcsrc), .alucontrol(d2_alucontrol), .immzext(d2_immzext),
        .instr_done(d2_instr_done), .halted(d2_halted), .state(d2_state)
    );

    assign act1 = {d1_pcen, d1_iord, d1_memwrite, d1_irwrite, d1_regwrite, d1_regdst, d1_memtoreg,
                   d1_alusrca, d1_alusrcb, d1_pcsrc, d1_alucontrol, d1_immzext, d1_instr_done,
                   d1_halted, d1_state};
    assign act2 = {d2_pcen, d2_iord, d2_memwrite, d2_irwrite, d2_regwrite, d2_regdst, d2_memtoreg,
                   d2_alusrca, d2_alusrcb, d2_pcsrc, d2_alucontrol, d2_immzext, d2_instr_done,
                   d2_halted, d2_state};

    // Field order matches act1/act2.
    function automatic logic [21:0] E(input logic [3:0] st, input logic pc, io, mw, ir, rw, rd, mt, sa,
                                      input logic [1:0] sb, ps, input logic [2:0] ac,
                                      input logic iz, dn, ht);
        return {pc, io, mw, ir, rw, rd, mt, sa, sb, ps, ac, iz, dn, ht, st};
    endfunction

    function automatic logic [21:0] EX(input logic [2:0] ac);
        return E(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, ac, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [21:0] IX(input logic [2:0] ac, input logic iz);
        return E(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, ac, iz, 1'b0, 1'b0);
    endfunction

    function automatic logic [21:0] BR(input logic z);
        return E(4'd8, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0, 1'b1, 1'b0);
    endfunction

    logic [21:0] XF, XD, XMA, XMR, XMWB, XMWR, XAWB, XIWB, XJP, XH;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [21:0] exp;
    } vec_t;
    vec_t vecs[$];

    localparam logic [5:0] JUNK = 6'b111111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, XORI = 6'b001110;
    localparam logic [5:0] JMP = 6'b000010;

    task automatic add(input logic [5:0] o, f, input logic z, input logic [21:0] e);
        vecs.push_back('{o, f, z, e});
    endtask

    task automatic chk(input string nm, input logic [21:0] got, input logic [21:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic step(input logic [5:0] o, f, input logic z);
        @(negedge clk);
        op = o;
        funct = f;
        zero = z;
        #1;
    endtask

    // State plus the signals that must be quiet while reset is held.
    function automatic logic [21:0] rst_view(input logic [21:0] a);
        return {12'd0, a[3:0], a[4], a[21], a[18], a[19], a[17], a[5]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] ac);
        add(JUNK, JUNK, 1'b0, XF);
        add(RT, f, 1'b0, XD);
        add(RT, f, 1'b0, EX(ac));
        add(RT, f, 1'b0, XAWB);
    endtask

    task automatic imm(input logic [5:0] o, input logic [2:0] ac, input logic iz);
        add(JUNK, JUNK, 1'b0, XF);
        add(o, JUNK, 1'b0, XD);
        add(o, JUNK, 1'b0, IX(ac, iz));
        add(o, JUNK, 1'b0, XIWB);
    endtask

    initial begin
        XF   = E(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);
        XD   = E(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);
        XMA  = E(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);
        XMR  = E(4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);
        XMWB = E(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0);
        XMWR = E(4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0);
        XAWB = E(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0);
        XIWB = E(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0);
        XJP  = E(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'b010, 1'b0, 1'b1, 1'b0);
        XH   = E(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1);

        // lw, sw
        add(JUNK, JUNK, 1'b0, XF);
        add(LW, JUNK, 1'b0, XD);
        add(LW, JUNK, 1'b0, XMA);
        add(LW, JUNK, 1'b0, XMR);
        add(LW, JUNK, 1'b0, XMWB);
        add(JUNK, JUNK, 1'b1, XF);
        add(SW, JUNK, 1'b1, XD);
        add(SW, JUNK, 1'b1, XMA);
        add(SW, JUNK, 1'b1, XMWR);
        // R-type
        rtype(6'b100000, 3'b010);
        rtype(6'b100010, 3'b110);
        rtype(6'b100100, 3'b000);
        rtype(6'b100101, 3'b001);
        rtype(6'b101010, 3'b111);
        rtype(6'b100110, 3'b011);
        rtype(6'b100111, 3'b100);
        // beq taken (zero high already in DECODE must not raise pcen), then not taken
        add(JUNK, JUNK, 1'b0, XF);
        add(BEQ, JUNK, 1'b1, XD);
        add(BEQ, JUNK, 1'b1, BR(1'b1));
        add(JUNK, JUNK, 1'b1, XF);
        add(BEQ, JUNK, 1'b0, XD);
        add(BEQ, JUNK, 1'b0, BR(1'b0));
        // immediates
        imm(ORI,  3'b001, 1'b1);
        imm(ADDI, 3'b010, 1'b0);
        imm(ANDI, 3'b000, 1'b1);
        imm(XORI, 3'b011, 1'b1);
        // jump
        add(JUNK, JUNK, 1'b0, XF);
        add(JMP, JUNK, 1'b0, XD);
        add(JMP, JUNK, 1'b0, XJP);
        // illegal funct halts and stays halted
        add(JUNK, JUNK, 1'b0, XF);
        add(RT, 6'b111111, 1'b0, XD);
        for (int k = 0; k < 10; k++) add(RT, 6'b111111, 1'b0, XH);

        reset = 1'b0;
        op = JUNK;
        funct = JUNK;
        zero = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset_held", rst_view(act1), 22'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].funct, vecs[i].zero);
            chk($sformatf("vec%0d", i), act1, vecs[i].exp);
        end

        // Asynchronous reset out of HALT, then FETCH visible before the first edge
        #2 reset = 1'b0;
        #1 chk("reset_in_halt", rst_view(act1), 22'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        step(JUNK, JUNK, 1'b0);
        chk("fetch_after_reset", act1, XF);

        // Illegal funct: dut1 halts, dut2 refetches in cycle 3
        step(RT, 6'b111111, 1'b0);
        chk("illf_decode", act2, XD);
        step(RT, 6'b111111, 1'b0);
        chk("illf_halt", act1, XH);
        chk("illf_nohalt_fetch", act2, XF);

        // Illegal opcode
        do_reset();
        step(JUNK, JUNK, 1'b0);
        step(6'b110000, JUNK, 1'b0);
        step(6'b110000, JUNK, 1'b0);
        chk("illop_halt", act1, XH);
        chk("illop_nohalt_fetch", act2, XF);

        // Reset pulse during MEMRD, then lw restarts cleanly
        do_reset();
        step(JUNK, JUNK, 1'b0);
        step(LW, JUNK, 1'b0);
        step(LW, JUNK, 1'b0);
        step(LW, JUNK, 1'b0);
        chk("pre_reset_memrd", act1, XMR);
        #2 reset = 1'b0;
        #1 chk("reset_in_memrd", rst_view(act1), 22'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        step(JUNK, JUNK, 1'b0);
        chk("lw2_fetch", act1, XF);
        step(LW, JUNK, 1'b0);
        chk("lw2_decode", act1, XD);
        step(LW, JUNK, 1'b0);
        chk("lw2_memadr", act1, XMA);
        step(LW, JUNK, 1'b0);
        chk("lw2_memrd", act1, XMR);
        step(LW, JUNK, 1'b0);
        chk("lw2_memwb", act1, XMWB);
        step(JUNK, JUNK, 1'b0);
        chk("lw2_next_fetch", act1, XF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
